jk_cmd_debouncer: RTL

//  Upstream command stage for the JK flip-flop block. Takes three raw, asynchronous,

---
 rtl/jk_cmd_pkg.sv | 22 ++
 rtl/jk_cmd_debouncer_if.sv | 25 ++
 rtl/debounce_channel.sv | 69 ++++++
 rtl/jk_cmd_debouncer.sv | 66 ++++++
 4 files changed

// File: rtl/jk_cmd_pkg.sv
// Shared constants and helpers for the JK command debouncer.
// Channel indices match the bit order of the debounced 'stable' vector.
package jk_cmd_pkg;

    localparam int unsigned CH_SET = 0;
    localparam int unsigned CH_CLR = 1;
    localparam int unsigned CH_TOG = 2;
    localparam int unsigned NUM_CH = 3;

    // Ceiling log2, usable in constant expressions for counter widths.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/jk_cmd_debouncer_if.sv
// Button/command bundle between the push-button front end and the JK flip-flop block.
// 'press' exposes the raw per-channel accepted-press strobes before enable masking.
interface jk_cmd_debouncer_if;
    import jk_cmd_pkg::*;

    logic              en;
    logic              btn_set;
    logic              btn_clr;
    logic              btn_tog;
    logic              j;
    logic              k;
    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] press;

    modport master (
        output en, btn_set, btn_clr, btn_tog,
        input  j, k, stable, press
    );

    modport slave (
        input  en, btn_set, btn_clr, btn_tog,
        output j, k, stable, press
    );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: synchroniser chain, stability counter and rising-press strobe.
// press_c is the next-cycle value of press, so a downstream register can align with it.
module debounce_channel #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press,
    output logic press_c
);
    import jk_cmd_pkg::*;

    localparam int unsigned      CNT_W   = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   press_q;

    assign s = sync_q[SYNC_STAGES-1];

    // Metastability chain for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // A differing level must persist DEBOUNCE_CYCLES cycles; any return restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_c  = 1'b0;
        if (s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d    = '0;
            stable_d = s;
            press_c  = s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_c;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/jk_cmd_debouncer.sv
// Debounces set/clear/toggle buttons and encodes accepted presses as one-cycle j/k commands.
// j/k register on the same edge as the channel press strobes; en=0 drops a command outright.
module jk_cmd_debouncer
    import jk_cmd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    jk_cmd_debouncer_if.slave  bus
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] press;
    logic [NUM_CH-1:0] press_c;
    logic              j_d;
    logic              k_d;
    logic              j_q;
    logic              k_q;

    assign raw[CH_SET] = bus.btn_set;
    assign raw[CH_CLR] = bus.btn_clr;
    assign raw[CH_TOG] = bus.btn_tog;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .raw     (raw[ch]),
            .stable  (stable[ch]),
            .press   (press[ch]),
            .press_c (press_c[ch])
        );
    end

    // Toggle, or set and clear together, both yield j=k=1.
    always_comb begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (bus.en) begin
            j_d = press_c[CH_SET] | press_c[CH_TOG];
            k_d = press_c[CH_CLR] | press_c[CH_TOG];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            j_q <= 1'b0;
            k_q <= 1'b0;
        end else begin
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign bus.j      = j_q;
    assign bus.k      = k_q;
    assign bus.stable = stable;
    assign bus.press  = press;

endmodule
